// File: rtl/wb_complete_arbiter.sv
// Writeback arbiter between the functional units (alu1, alu2, mem) and the
// complete stage. It buffers each unit's results in a small FIFO and forwards
// up to two of the oldest heads per cycle, ranked by ROB age, onto two
// registered writeback ports.

package typedefs;
    localparam int ROB_SIZE_BITS = 4;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              pc;
        logic [4:0]               rd;
        logic [5:0]               rd_old;
        logic [31:0]              result;
        logic [31:0]              mem_data;
        logic [7:0]               control;
        logic [ROB_SIZE_BITS-1:0] robNum;
    } completeStruct;

    typedef struct packed {
        logic alu1;
        logic alu2;
        logic mem;
    } fuRdyStruct;
endpackage

module wb_complete_arbiter
    import typedefs::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned ROB_BITS  = typedefs::ROB_SIZE_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  completeStruct       alu1_in,
    input  completeStruct       alu2_in,
    input  completeStruct       mem_in,
    input  logic [ROB_BITS-1:0] rob_head,
    input  logic                wb_stall,
    input  logic                flush,
    output fuRdyStruct          fu_rdy,
    output completeStruct       wb0_out,
    output completeStruct       wb1_out,
    output logic                overflow_err
);

    localparam int unsigned NUM_FU = 3;
    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);

    // Unit index order: 0 = alu1, 1 = alu2, 2 = mem.
    completeStruct       fu_in   [NUM_FU];
    completeStruct       fifo_q  [NUM_FU][BUF_DEPTH];
    completeStruct       fifo_d  [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q[NUM_FU];
    logic [PTR_W-1:0]    wr_ptr_d[NUM_FU];
    logic [PTR_W-1:0]    rd_ptr_q[NUM_FU];
    logic [PTR_W-1:0]    rd_ptr_d[NUM_FU];
    logic [CNT_W-1:0]    count_q [NUM_FU];
    logic [CNT_W-1:0]    count_d [NUM_FU];

    completeStruct       head    [NUM_FU];
    logic [ROB_BITS-1:0] age     [NUM_FU];
    logic [1:0]          rank    [NUM_FU];
    logic [NUM_FU-1:0]   cand;
    logic [NUM_FU-1:0]   full;
    logic [NUM_FU-1:0]   push;
    logic [NUM_FU-1:0]   drop;
    logic [NUM_FU-1:0]   pop;

    logic                sel0_vld;
    logic                sel1_vld;
    logic [1:0]          sel0_idx;
    logic [1:0]          sel1_idx;

    completeStruct       wb0_q;
    completeStruct       wb0_d;
    completeStruct       wb1_q;
    completeStruct       wb1_d;
    logic                overflow_q;
    logic                overflow_d;

    // Tie-break weight for equal ages: mem > alu1 > alu2.
    function automatic logic [1:0] fu_prio(input int unsigned idx);
        case (idx)
            0:       return 2'd1;
            1:       return 2'd0;
            default: return 2'd2;
        endcase
    endfunction

    // True when candidate a should be written back before candidate b.
    function automatic logic is_older(input logic [ROB_BITS-1:0] age_a,
                                      input logic [1:0]          prio_a,
                                      input logic [ROB_BITS-1:0] age_b,
                                      input logic [1:0]          prio_b);
        return (age_a < age_b) || ((age_a == age_b) && (prio_a > prio_b));
    endfunction

    // Gather the unit inputs into an indexable array.
    always_comb begin
        fu_in[0] = alu1_in;
        fu_in[1] = alu2_in;
        fu_in[2] = mem_in;
    end

    // FIFO heads, candidacy and wrapped distance from the ROB head.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            head[i] = fifo_q[i][rd_ptr_q[i]];
            cand[i] = (count_q[i] != '0);
            age[i]  = ROB_BITS'(head[i].robNum) - rob_head;
        end
    end

    // Rank each candidate by how many other candidates are older than it;
    // rank 0 goes to wb0 and rank 1 to wb1.
    always_comb begin
        sel0_vld = 1'b0;
        sel1_vld = 1'b0;
        sel0_idx = '0;
        sel1_idx = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            rank[i] = '0;
            for (int unsigned j = 0; j < NUM_FU; j++) begin
                if (j != i && cand[j] &&
                    is_older(age[j], fu_prio(j), age[i], fu_prio(i))) begin
                    rank[i] = rank[i] + 2'd1;
                end
            end
            if (cand[i] && rank[i] == 2'd0) begin
                sel0_vld = 1'b1;
                sel0_idx = 2'(i);
            end
            if (cand[i] && rank[i] == 2'd1) begin
                sel1_vld = 1'b1;
                sel1_idx = 2'(i);
            end
        end
    end

    // Push/pop decisions and next pointer/count state; flush wins over all.
    always_comb begin
        overflow_d = overflow_q;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            full[i] = (count_q[i] == CNT_W'(BUF_DEPTH));
            push[i] = fu_in[i].valid && !full[i] && !flush;
            drop[i] = fu_in[i].valid &&  full[i] && !flush;
            pop[i]  = cand[i] && (rank[i] < 2'd2) && !wb_stall && !flush;
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
                count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (drop[i]) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Write accepted results into FIFO storage.
    always_comb begin
        fifo_d = fifo_q;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                fifo_d[i][wr_ptr_q[i]] = fu_in[i];
            end
        end
    end

    // Next writeback port contents; stall and flush yield an empty cycle.
    always_comb begin
        wb0_d = '0;
        wb1_d = '0;
        if (!flush && !wb_stall) begin
            if (sel0_vld) begin
                wb0_d       = head[sel0_idx];
                wb0_d.valid = 1'b1;
            end
            if (sel1_vld) begin
                wb1_d       = head[sel1_idx];
                wb1_d.valid = 1'b1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            wb0_q      <= '0;
            wb1_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            wb0_q      <= wb0_d;
            wb1_q      <= wb1_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage needs no reset; counts alone define occupancy.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign fu_rdy.alu1  = ~full[0];
    assign fu_rdy.alu2  = ~full[1];
    assign fu_rdy.mem   = ~full[2];
    assign wb0_out      = wb0_q;
    assign wb1_out      = wb1_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_wb_complete_arbiter.sv
// Self-checking bench for wb_complete_arbiter: each test loads a per-cycle
// stimulus table and the writebacks it must produce into a scoreboard queue,
// then pops and compares one expectation per cycle on the falling edge.

module tb_wb_complete_arbiter;
    import typedefs::*;

    logic          clk = 1'b0;
    logic          rst_n;
    completeStruct alu1_in, alu2_in, mem_in;
    completeStruct wb0_out, wb1_out;
    logic [3:0]    rob_head;
    logic          wb_stall, flush;
    fuRdyStruct    fu_rdy;
    logic          overflow_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic a1v; logic [3:0] a1;
        logic a2v; logic [3:0] a2;
        logic mv;  logic [3:0] m;
        logic [3:0] head;
        logic stall;
        logic fl;
    } stim_t;

    typedef struct {
        logic v0; logic [3:0] r0;
        logic v1; logic [3:0] r1;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    wb_complete_arbiter #(.BUF_DEPTH(2), .ROB_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu1_in      (alu1_in),
        .alu2_in      (alu2_in),
        .mem_in       (mem_in),
        .rob_head     (rob_head),
        .wb_stall     (wb_stall),
        .flush        (flush),
        .fu_rdy       (fu_rdy),
        .wb0_out      (wb0_out),
        .wb1_out      (wb1_out),
        .overflow_err (overflow_err)
    );

    // Payload derived from robNum so passthrough can be checked.
    function automatic logic [31:0] pay(input logic [3:0] r);
        return 32'hC0DE_0000 + 32'(r) * 32'd4099;
    endfunction

    function automatic completeStruct mk(input logic v, input logic [3:0] r);
        completeStruct c;
        c.valid    = v;
        c.pc       = ~pay(r);
        c.rd       = 5'(r) + 5'd1;
        c.rd_old   = 6'(r) + 6'd7;
        c.result   = pay(r);
        c.mem_data = pay(r) ^ 32'h5A5A_5A5A;
        c.control  = 8'(r);
        c.robNum   = r;
        return c;
    endfunction

    function automatic stim_t st(input logic a1v, input logic [3:0] a1,
                                 input logic a2v, input logic [3:0] a2,
                                 input logic mv,  input logic [3:0] m,
                                 input logic [3:0] head, input logic stall,
                                 input logic fl);
        stim_t s;
        s.a1v = a1v; s.a1 = a1; s.a2v = a2v; s.a2 = a2;
        s.mv = mv; s.m = m; s.head = head; s.stall = stall; s.fl = fl;
        return s;
    endfunction

    function automatic stim_t idle(input logic [3:0] head);
        return st(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, head, 1'b0, 1'b0);
    endfunction

    function automatic exp_t ex(input logic v0, input logic [3:0] r0,
                                input logic v1, input logic [3:0] r1);
        exp_t e;
        e.v0 = v0; e.r0 = r0; e.v1 = v1; e.r1 = r1;
        return e;
    endfunction

    function automatic logic [73:0] exp_vec(input exp_t e);
        return {e.v0, e.v0 ? e.r0 : 4'd0, e.v0 ? pay(e.r0) : 32'd0,
                e.v1, e.v1 ? e.r1 : 4'd0, e.v1 ? pay(e.r1) : 32'd0};
    endfunction

    function automatic logic [73:0] obs_vec();
        return {wb0_out.valid, wb0_out.valid ? wb0_out.robNum : 4'd0,
                wb0_out.valid ? wb0_out.result : 32'd0,
                wb1_out.valid, wb1_out.valid ? wb1_out.robNum : 4'd0,
                wb1_out.valid ? wb1_out.result : 32'd0};
    endfunction

    task automatic apply(input stim_t s);
        alu1_in  = mk(s.a1v, s.a1);
        alu2_in  = mk(s.a2v, s.a2);
        mem_in   = mk(s.mv, s.m);
        rob_head = s.head;
        wb_stall = s.stall;
        flush    = s.fl;
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(st(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                     1'($urandom), 4'($urandom), 4'($urandom),
                     1'($urandom), 1'($urandom)));
        end
        @(negedge clk);
        total_cnt++;
        if (fu_rdy !== 3'b111) $display("FAIL reset_fu_rdy got=%b exp=111", fu_rdy);
        else pass_cnt++;
        total_cnt++;
        if ({wb0_out, wb1_out} !== '0) $display("FAIL reset_wb got=%h exp=0", {wb0_out, wb1_out});
        else pass_cnt++;
        total_cnt++;
        if (overflow_err !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow_err);
        else pass_cnt++;
        apply(idle(4'd0));
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL reset_release c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   n;
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(st(1, 4'd3, 0, 0, 0, 0, 4'd0, 0, 0));
        repeat (3) stim_q.push_back(idle(4'd0));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(1, 4'd3, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL single c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
            apply(stim_q[c]);
        end
    endtask

    task automatic test_three();
        exp_t e;
        int   n;
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(st(1, 4'd5, 1, 4'd2, 1, 4'd9, 4'd0, 0, 0));
        repeat (4) stim_q.push_back(idle(4'd0));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(1, 4'd2, 1, 4'd5));
        exp_q.push_back(ex(1, 4'd9, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL three c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
            apply(stim_q[c]);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   n;
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(st(1, 4'd15, 1, 4'd14, 1, 4'd1, 4'd14, 0, 0));
        repeat (4) stim_q.push_back(idle(4'd14));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(1, 4'd14, 1, 4'd15));
        exp_q.push_back(ex(1, 4'd1, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL wrap c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
            apply(stim_q[c]);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        int   n;
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(st(0, 0, 1, 4'd5, 1, 4'd3, 4'd0, 1, 0));
        stim_q.push_back(st(0, 0, 0, 0, 1, 4'd4, 4'd0, 1, 0));
        stim_q.push_back(st(1, 4'd6, 0, 0, 0, 0, 4'd0, 0, 1));
        stim_q.push_back(idle(4'd0));
        stim_q.push_back(idle(4'd0));
        stim_q.push_back(st(1, 4'd8, 0, 0, 0, 0, 4'd0, 0, 0));
        repeat (3) stim_q.push_back(idle(4'd0));
        repeat (7) exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(1, 4'd8, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL flush c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
            if (c == 2) begin
                total_cnt++;
                if (fu_rdy.mem !== 1'b0) $display("FAIL flush_mem_full got=%b exp=0", fu_rdy.mem);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if (fu_rdy !== 3'b111) $display("FAIL flush_fu_rdy got=%b exp=111", fu_rdy);
                else pass_cnt++;
                total_cnt++;
                if (overflow_err !== 1'b0) $display("FAIL flush_ovf got=%b exp=0", overflow_err);
                else pass_cnt++;
            end
            apply(stim_q[c]);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int   n;
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(st(1, 4'd4, 0, 0, 0, 0, 4'd0, 1, 0));
        stim_q.push_back(st(1, 4'd6, 0, 0, 0, 0, 4'd0, 1, 0));
        stim_q.push_back(st(1, 4'd7, 0, 0, 0, 0, 4'd0, 1, 0));
        repeat (5) stim_q.push_back(idle(4'd0));
        repeat (4) exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(1, 4'd4, 0, 0));
        exp_q.push_back(ex(1, 4'd6, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL overflow c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (fu_rdy.alu1 !== 1'b1) $display("FAIL ovf_rdy_one got=%b exp=1", fu_rdy.alu1);
                else pass_cnt++;
            end
            if (c == 2) begin
                total_cnt++;
                if (fu_rdy.alu1 !== 1'b0) $display("FAIL ovf_rdy_full got=%b exp=0", fu_rdy.alu1);
                else pass_cnt++;
                total_cnt++;
                if (overflow_err !== 1'b0) $display("FAIL ovf_early got=%b exp=0", overflow_err);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if (overflow_err !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow_err);
                else pass_cnt++;
            end
            if (c == 7) begin
                total_cnt++;
                if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow_err);
                else pass_cnt++;
            end
            apply(stim_q[c]);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   n;
        @(negedge clk);
        apply(st(1, 4'd2, 0, 0, 0, 0, 4'd0, 0, 0));
        @(negedge clk);
        apply(idle(4'd0));
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (overflow_err !== 1'b0) $display("FAIL areset_ovf got=%b exp=0", overflow_err);
        else pass_cnt++;
        total_cnt++;
        if (fu_rdy !== 3'b111) $display("FAIL areset_fu_rdy got=%b exp=111", fu_rdy);
        else pass_cnt++;
        #1 rst_n = 1'b1;
        exp_q.delete();
        repeat (3) exp_q.push_back(ex(0, 0, 0, 0));
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_vec() !== exp_vec(e)) $display("FAIL areset_lost c%0d got=%h exp=%h", c, obs_vec(), exp_vec(e));
            else pass_cnt++;
        end
    endtask

    initial begin
        apply(idle(4'd0));
        test_reset();
        test_single();
        test_three();
        test_wrap();
        test_flush();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
